// File: rtl/spike_classifier_pkg.sv
// Shared types for the spike classifier: FSM state encoding and step-counter width.
// Optional margin outputs are enabled by SPK_CLS_MARGIN_EN (see spike_classifier.sv).
package snn_cls_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DECIDE = 2'd2,
      DONE   = 2'd3
   } cls_state_t;

   localparam int STEP_W = 16;

   // Class index width, never narrower than one bit
   function automatic int cls_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spike_classifier_if.sv
// Host-side bus of the spike classifier: window control, spike input, result handshake.
// SPK_CLS_MARGIN_EN adds min_margin / margin / low_conf.
interface spike_classifier_if
   import snn_cls_pkg::*;
#(
   parameter int N_OUT = 2,
   parameter int CNT_W = 8
);
   localparam int CLS_W = cls_w(N_OUT);

   logic                   pulse;
   logic                   start;
   logic [N_OUT-1:0]       spike_in;
   logic                   ack;
   logic                   busy;
   logic                   valid;
   logic [CLS_W-1:0]       class_out;
   logic [CNT_W-1:0]       win_count;
   logic [N_OUT*CNT_W-1:0] counts;
`ifdef SPK_CLS_MARGIN_EN
   logic [CNT_W-1:0]       min_margin;
   logic [CNT_W-1:0]       margin;
   logic                   low_conf;

   modport master (
      output pulse, start, spike_in, ack, min_margin,
      input  busy, valid, class_out, win_count, counts, margin, low_conf
   );
   modport slave (
      input  pulse, start, spike_in, ack, min_margin,
      output busy, valid, class_out, win_count, counts, margin, low_conf
   );
`else
   modport master (
      output pulse, start, spike_in, ack,
      input  busy, valid, class_out, win_count, counts
   );
   modport slave (
      input  pulse, start, spike_in, ack,
      output busy, valid, class_out, win_count, counts
   );
`endif

endinterface

// File: rtl/spike_counter.sv
// One saturating per-neuron spike counter with synchronous clear and count enable.
module spike_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_spike,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset || i_clr) begin
         r_count <= '0;
      end else if (i_en && i_spike && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/spike_classifier.sv
// Counts output-neuron spikes over WINDOW pulses and reports the argmax via valid/ack.
// Define SPK_CLS_MARGIN_EN to add the winner-vs-runner-up margin and low-confidence flag.
module spike_classifier
   import snn_cls_pkg::*;
#(
   parameter int N_OUT  = 2,
   parameter int CNT_W  = 8,
   parameter int WINDOW = 100
) (
   input  logic              clk,
   input  logic              reset,
   spike_classifier_if.slave bus
);

   localparam int CLS_W = cls_w(N_OUT);

   cls_state_t             r_state;
   cls_state_t             w_next;
   logic [STEP_W-1:0]      r_step;
   logic                   w_clr;
   logic                   w_cnt_en;
   logic                   w_last;
   logic [CNT_W-1:0]       w_cnt [N_OUT];
   logic [N_OUT*CNT_W-1:0] w_counts;
   logic [CLS_W-1:0]       w_best_idx;
   logic [CNT_W-1:0]       w_best;
   logic [CLS_W-1:0]       r_class;
   logic [CNT_W-1:0]       r_win;

   assign w_clr    = (r_state == IDLE) && bus.start;
   assign w_cnt_en = (r_state == ACCUM) && bus.pulse;
   assign w_last   = w_cnt_en && (r_step == STEP_W'(WINDOW - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = ACCUM;
         ACCUM:   if (w_last)    w_next = DECIDE;
         DECIDE:                 w_next = DONE;
         DONE:    if (bus.ack)   w_next = IDLE;
         default:                w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || w_clr) begin
         r_step <= '0;
      end else if (w_cnt_en) begin
         r_step <= r_step + 1'b1;
      end
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
      spike_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .i_clr   (w_clr),
         .i_en    (w_cnt_en),
         .i_spike (bus.spike_in[g]),
         .o_count (w_cnt[g])
      );
   end

   always_comb begin
      w_counts = '0;
      for (int i = 0; i < N_OUT; i++) begin
         w_counts[i*CNT_W +: CNT_W] = w_cnt[i];
      end
   end

`ifdef SPK_CLS_MARGIN_EN
   logic [CNT_W-1:0] w_second;
   logic [CNT_W-1:0] w_margin;
   logic [CNT_W-1:0] r_margin;
   logic             r_low_conf;
`endif

   // Strict '>' keeps the earliest index on ties; the displaced best becomes runner-up
   always_comb begin
      w_best     = '0;
      w_best_idx = '0;
`ifdef SPK_CLS_MARGIN_EN
      w_second   = '0;
`endif
      for (int i = 0; i < N_OUT; i++) begin
         if (w_cnt[i] > w_best) begin
`ifdef SPK_CLS_MARGIN_EN
            w_second   = w_best;
`endif
            w_best     = w_cnt[i];
            w_best_idx = CLS_W'(i);
         end
`ifdef SPK_CLS_MARGIN_EN
         else if (w_cnt[i] > w_second) begin
            w_second = w_cnt[i];
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_class <= '0;
         r_win   <= '0;
      end else if (r_state == DECIDE) begin
         r_class <= w_best_idx;
         r_win   <= w_best;
      end
   end

`ifdef SPK_CLS_MARGIN_EN
   assign w_margin = w_best - w_second;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_margin   <= '0;
         r_low_conf <= 1'b0;
      end else if (r_state == DECIDE) begin
         r_margin   <= w_margin;
         r_low_conf <= (w_margin < bus.min_margin);
      end
   end

   assign bus.margin   = r_margin;
   assign bus.low_conf = r_low_conf;
`endif

   assign bus.busy      = (r_state == ACCUM) || (r_state == DECIDE);
   assign bus.valid     = (r_state == DONE);
   assign bus.class_out = r_class;
   assign bus.win_count = r_win;
   assign bus.counts    = w_counts;

endmodule

// File: tb/tb_spike_classifier.sv
// Directed bench for spike_classifier: one 8-bit/10-pulse instance and one 4-bit/20-pulse instance.
// Margin checks are compiled only when SPK_CLS_MARGIN_EN is defined.
module tb_spike_classifier;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   spike_classifier_if #(.N_OUT(2), .CNT_W(8)) ifa ();
   spike_classifier_if #(.N_OUT(2), .CNT_W(4)) ifb ();

   spike_classifier #(.N_OUT(2), .CNT_W(8), .WINDOW(10)) u_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   spike_classifier #(.N_OUT(2), .CNT_W(4), .WINDOW(20)) u_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full window on instance A; spike patterns issued in order 11, 01, 10, 00 with noisy gaps
   task automatic run_a(input int n11, input int n01, input int n10, input int n00,
                        input logic [15:0] exp_counts, input int exp_cls, input int exp_win);
      int total;
      total = n11 + n01 + n10 + n00;
      ifa.start    = 1'b1;
      ifa.pulse    = 1'b1;
      ifa.spike_in = 2'b11;
      tick();
      ifa.start = 1'b0;
      ifa.pulse = 1'b0;
      check("a_busy_after_start", ifa.busy, 1);
      check("a_counts_cleared", ifa.counts, 0);
      for (int k = 0; k < total; k++) begin
         if (k > 0) begin
            ifa.pulse    = 1'b0;
            ifa.spike_in = 2'b11;
            tick();
         end
         ifa.pulse = 1'b1;
         if (k < n11)                  ifa.spike_in = 2'b11;
         else if (k < n11 + n01)       ifa.spike_in = 2'b01;
         else if (k < n11 + n01 + n10) ifa.spike_in = 2'b10;
         else                          ifa.spike_in = 2'b00;
         tick();
      end
      ifa.pulse    = 1'b0;
      ifa.spike_in = 2'b00;
      check("a_valid_in_decide", ifa.valid, 0);
      check("a_busy_in_decide", ifa.busy, 1);
      check("a_counts_final", ifa.counts, exp_counts);
      tick();
      check("a_valid_done", ifa.valid, 1);
      check("a_busy_done", ifa.busy, 0);
      check("a_class", ifa.class_out, exp_cls);
      check("a_win", ifa.win_count, exp_win);
   endtask

   task automatic ack_a();
      ifa.ack = 1'b1;
      tick();
      ifa.ack = 1'b0;
      check("a_valid_after_ack", ifa.valid, 0);
   endtask

   initial begin
      reset        = 1'b0;
      ifa.start    = 1'b0;
      ifa.pulse    = 1'b0;
      ifa.spike_in = '0;
      ifa.ack      = 1'b0;
      ifb.start    = 1'b0;
      ifb.pulse    = 1'b0;
      ifb.spike_in = '0;
      ifb.ack      = 1'b0;
`ifdef SPK_CLS_MARGIN_EN
      ifa.min_margin = 8'd3;
      ifb.min_margin = 4'd0;
`endif
      tick();
      tick();
      check("rst_busy", ifa.busy, 0);
      check("rst_valid", ifa.valid, 0);
      check("rst_class", ifa.class_out, 0);
      check("rst_win", ifa.win_count, 0);
      check("rst_counts", ifa.counts, 0);
      check("rst_b_counts", ifb.counts, 0);
      reset = 1'b1;
      tick();

      // Basic: neuron1 gets 7, neuron0 gets 3
      run_a(0, 3, 7, 0, 16'h0703, 1, 7);

      // Hold in DONE with start and pulse activity; nothing may move
      for (int i = 0; i < 50; i++) begin
         ifa.start    = i[0];
         ifa.pulse    = 1'b1;
         ifa.spike_in = 2'b11;
         tick();
      end
      ifa.start = 1'b0;
      ifa.pulse = 1'b0;
      check("hold_valid", ifa.valid, 1);
      check("hold_busy", ifa.busy, 0);
      check("hold_class", ifa.class_out, 1);
      check("hold_win", ifa.win_count, 7);
      check("hold_counts", ifa.counts, 16'h0703);
      ack_a();
      check("idle_busy", ifa.busy, 0);
      check("idle_counts_held", ifa.counts, 16'h0703);
      check("idle_class_held", ifa.class_out, 1);

      // Tie resolves to lowest index
      run_a(5, 0, 0, 5, 16'h0505, 0, 5);
      ack_a();

      // Reset in the middle of a window
      ifa.start = 1'b1;
      tick();
      ifa.start    = 1'b0;
      ifa.pulse    = 1'b1;
      ifa.spike_in = 2'b01;
      for (int i = 0; i < 4; i++) tick();
      ifa.pulse = 1'b0;
      check("mid_counts", ifa.counts, 16'h0004);
      check("mid_busy", ifa.busy, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mrst_busy", ifa.busy, 0);
      check("mrst_valid", ifa.valid, 0);
      check("mrst_class", ifa.class_out, 0);
      check("mrst_win", ifa.win_count, 0);
      check("mrst_counts", ifa.counts, 0);
      run_a(0, 0, 0, 10, 16'h0000, 0, 0);
      ack_a();

`ifdef SPK_CLS_MARGIN_EN
      run_a(4, 2, 0, 4, 16'h0406, 0, 6);
      check("m1_margin", ifa.margin, 2);
      check("m1_low_conf", ifa.low_conf, 1);
      ack_a();
      run_a(1, 8, 0, 1, 16'h0109, 0, 9);
      check("m2_margin", ifa.margin, 8);
      check("m2_low_conf", ifa.low_conf, 0);
      ack_a();
`endif

      // Saturation on the 4-bit instance: neuron0 spikes on all 20 pulses
      ifb.start = 1'b1;
      tick();
      ifb.start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         ifb.pulse    = 1'b1;
         ifb.spike_in = 2'b01;
         tick();
         ifb.pulse = 1'b0;
         if (k == 14) check("sat_b_at15", ifb.counts, 8'h0F);
         if (k < 19) tick();
      end
      ifb.spike_in = 2'b00;
      check("sat_b_decide_valid", ifb.valid, 0);
      tick();
      check("sat_b_valid", ifb.valid, 1);
      check("sat_b_counts", ifb.counts, 8'h0F);
      check("sat_b_class", ifb.class_out, 0);
      check("sat_b_win", ifb.win_count, 15);
      ifb.ack = 1'b1;
      tick();
      ifb.ack = 1'b0;
      check("sat_b_ack", ifb.valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
